// File: rtl/adt7320_pkg.sv
// rtl/adt7320_pkg.sv - register map, defaults and FSM encoding shared by emulator, master and benches
package adt7320_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CONFIG = 3'd1;
    localparam logic [2:0] ADDR_TEMP   = 3'd2;
    localparam logic [2:0] ADDR_ID     = 3'd3;
    localparam logic [2:0] ADDR_T_CRIT = 3'd4;
    localparam logic [2:0] ADDR_T_HYST = 3'd5;
    localparam logic [2:0] ADDR_T_HIGH = 3'd6;
    localparam logic [2:0] ADDR_T_LOW  = 3'd7;

    localparam logic [7:0]  STATUS_DEFAULT = 8'h80;
    localparam logic [7:0]  CONFIG_DEFAULT = 8'h00;
    localparam logic [7:0]  ID_DEFAULT     = 8'hC3;
    localparam logic [15:0] T_CRIT_DEFAULT = 16'h4980;
    localparam logic [7:0]  T_HYST_DEFAULT = 8'h05;
    localparam logic [15:0] T_HIGH_DEFAULT = 16'h2000;
    localparam logic [15:0] T_LOW_DEFAULT  = 16'h0500;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_WAIT_CS = 3'd4
    } state_t;

    // 16-bit registers; everything else is an 8-bit register
    function automatic logic is_wide(input logic [2:0] addr);
        return (addr inside {ADDR_TEMP, ADDR_T_CRIT, ADDR_T_HIGH, ADDR_T_LOW});
    endfunction

    // Registers a master may change; status, temperature and ID are read-only
    function automatic logic is_writable(input logic [2:0] addr);
        return (addr inside {ADDR_CONFIG, ADDR_T_CRIT, ADDR_T_HYST, ADDR_T_HIGH, ADDR_T_LOW});
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rising/falling edge detect
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    // Chain idles high so a released reset never looks like an edge on an idle-high line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
            q_d   <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~q_d;
    assign fall = ~chain[STAGES-1] & q_d;

endmodule

// File: rtl/adt7320_emulator.sv
// rtl/adt7320_emulator.sv - SPI mode-3 slave emulating the ADT7320 register file
module adt7320_emulator
    import adt7320_pkg::*;
#(
    parameter logic [7:0] ID_VALUE    = ID_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        sclk,
    input  logic        din,
    output logic        dout,
    input  logic [15:0] temp_in,
    output logic [7:0]  cfg,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr
);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic [SYNC_STAGES-1:0] flush;
    logic                   cs_s;
    logic                   din_s;
    logic                   flush_done;
    logic                   cs_prev;
    logic                   cs_fall;
    logic                   sclk_rise;
    logic                   sclk_fall;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [5:0]  cmd_sr;
    logic [2:0]  addr;
    logic [15:0] shift_reg;
    logic [14:0] wdata;
    logic [15:0] wdata_next;
    logic [2:0]  cmd_addr;
    logic        cmd_rd;
    logic [15:0] read_word;
    logic [4:0]  last_idx;
    logic        commit_pend;

    logic [7:0]  cfg_reg;
    logic [15:0] t_crit;
    logic [7:0]  t_hyst;
    logic [15:0] t_high;
    logic [15:0] t_low;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_edge (
        .clk   (clk),
        .reset (reset),
        .d     (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Plain synchronizers for cs and din; flush marks when cs_sync holds real samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync  <= '1;
            din_sync <= '1;
            flush    <= '0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            din_sync <= {din_sync[SYNC_STAGES-2:0], din};
            flush    <= {flush[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign din_s      = din_sync[SYNC_STAGES-1];
    assign flush_done = flush[SYNC_STAGES-1];
    // cs_prev only arms on a genuinely observed high, so cs held low across reset is no edge
    assign cs_fall    = cs_prev & ~cs_s;

    // After seven command bits cmd_sr holds cmd[6:1]; the eighth bit is not needed
    assign cmd_rd     = cmd_sr[5];
    assign cmd_addr   = cmd_sr[4:2];
    assign wdata_next = {wdata, din_s};
    assign last_idx   = is_wide(addr) ? 5'd15 : 5'd7;
    assign cfg        = cfg_reg;

    // Read data selection; 8-bit registers are left-justified in the 16-bit frame
    always_comb begin
        read_word = 16'hFFFF;
        case (cmd_addr)
            ADDR_STATUS: read_word = {STATUS_DEFAULT, 8'h00};
            ADDR_CONFIG: read_word = {cfg_reg, 8'h00};
            ADDR_TEMP:   read_word = temp_in;
            ADDR_ID:     read_word = {ID_VALUE, 8'h00};
            ADDR_T_CRIT: read_word = t_crit;
            ADDR_T_HYST: read_word = {t_hyst, 8'h00};
            ADDR_T_HIGH: read_word = t_high;
            ADDR_T_LOW:  read_word = t_low;
            default:     read_word = 16'hFFFF;
        endcase
    end

    // Transfer FSM, register file and write-commit reporting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 5'd0;
            cmd_sr      <= 6'd0;
            addr        <= 3'd0;
            shift_reg   <= 16'hFFFF;
            wdata       <= 15'd0;
            dout        <= 1'b1;
            cs_prev     <= 1'b0;
            commit_pend <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 3'd0;
            cfg_reg     <= CONFIG_DEFAULT;
            t_crit      <= T_CRIT_DEFAULT;
            t_hyst      <= T_HYST_DEFAULT;
            t_high      <= T_HIGH_DEFAULT;
            t_low       <= T_LOW_DEFAULT;
        end else begin
            cs_prev     <= cs_s & flush_done;
            commit_pend <= 1'b0;
            wr_strobe   <= commit_pend;
            if (commit_pend) begin
                wr_addr <= addr;
            end

            if (cs_s && state != ST_IDLE) begin
                // Deselect aborts whatever is in flight; partial data is simply dropped
                state   <= ST_IDLE;
                bit_cnt <= 5'd0;
                dout    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        dout <= 1'b1;
                        if (cs_fall) begin
                            state   <= ST_CMD;
                            bit_cnt <= 5'd0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= {cmd_sr[4:0], din_s};
                            if (bit_cnt == 5'd7) begin
                                addr    <= cmd_addr;
                                bit_cnt <= 5'd0;
                                if (cmd_rd) begin
                                    state     <= ST_READ;
                                    shift_reg <= read_word;
                                end else begin
                                    state <= ST_WRITE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (sclk_fall) begin
                            dout      <= shift_reg[15];
                            shift_reg <= {shift_reg[14:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            if (bit_cnt == 5'd15) begin
                                state   <= ST_WAIT_CS;
                                bit_cnt <= 5'd0;
                                dout    <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (sclk_rise) begin
                            wdata <= wdata_next[14:0];
                            if (bit_cnt == last_idx) begin
                                state   <= ST_WAIT_CS;
                                bit_cnt <= 5'd0;
                                if (is_writable(addr)) begin
                                    commit_pend <= 1'b1;
                                    case (addr)
                                        ADDR_CONFIG: cfg_reg <= wdata_next[7:0];
                                        ADDR_T_CRIT: t_crit  <= wdata_next;
                                        ADDR_T_HYST: t_hyst  <= wdata_next[7:0];
                                        ADDR_T_HIGH: t_high  <= wdata_next;
                                        ADDR_T_LOW:  t_low   <= wdata_next;
                                        default:     ;
                                    endcase
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_WAIT_CS: begin
                        dout <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        dout  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adt7320_emulator.sv
// tb/tb_adt7320_emulator.sv - scoreboard bench for the ADT7320 emulator
module tb_adt7320_emulator;
    import adt7320_pkg::*;

    localparam int H = 8;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        sclk;
    logic        din;
    logic        dout;
    logic [15:0] temp_in;
    logic [7:0]  cfg;
    logic        wr_strobe;
    logic [2:0]  wr_addr;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_rd[$];
    logic [2:0]  exp_wr[$];

    adt7320_emulator #(.ID_VALUE(8'hC3), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk      (sclk),
        .din       (din),
        .dout      (dout),
        .temp_in   (temp_in),
        .cfg       (cfg),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] c, input logic [15:0] d, input int nbits);
        logic [23:0] frame;
        frame = {c, d};
        cs = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 8 + nbits; i++) begin
            sclk = 1'b0;
            din  = frame[23-i];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
        end
        repeat (H) @(negedge clk);
        cs  = 1'b1;
        din = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    // Bus monitor: rebuilds each frame from the wires and scores completed reads
    initial begin
        logic [23:0] sh;
        int          bits;
        logic        ok;
        logic        last_sclk;
        forever begin
            @(negedge cs);
            bits      = 0;
            ok        = 1'b1;
            sh        = '0;
            last_sclk = sclk;
            while (cs === 1'b0) begin
                @(posedge sclk or negedge sclk or posedge cs or posedge reset);
                if (reset === 1'b1) ok = 1'b0;
                if (cs === 1'b0 && sclk === 1'b1 && last_sclk === 1'b0) begin
                    sh = {sh[22:0], (bits < 8) ? din : dout};
                    bits++;
                end
                last_sclk = sclk;
            end
            if (ok && bits == 24 && sh[22]) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read", {16'h0, sh[15:0]}, 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("read_addr%0d", sh[21:19]), {16'h0, sh[15:0]}, {16'h0, exp_rd.pop_front()});
                end
            end
        end
    end

    // Write monitor: every wr_strobe cycle must match a queued write address
    initial begin
        forever begin
            @(negedge clk);
            if (wr_strobe === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_wr_strobe", {29'h0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", {29'h0, wr_addr}, {29'h0, exp_wr.pop_front()});
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        cs      = 1'b1;
        sclk    = 1'b1;
        din     = 1'b1;
        temp_in = 16'h0C80;
        repeat (3) @(negedge clk);
        check("reset_dout", {31'h0, dout}, 32'h1);
        check("reset_wr_strobe", {31'h0, wr_strobe}, 32'h0);
        check("reset_wr_addr", {29'h0, wr_addr}, 32'h0);
        check("reset_cfg", {24'h0, cfg}, 32'h0);
        check("reset_state", 32'(dut.state), 32'(ST_IDLE));
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // ID register, clean and with junk in cmd[7] / cmd[2:0]
        exp_rd.push_back(16'hC300); spi_xfer(8'h58, 16'h0, 16);
        exp_rd.push_back(16'hC300); spi_xfer(8'hDD, 16'h0, 16);
        exp_rd.push_back(16'h8000); spi_xfer(8'h40, 16'h0, 16);
        exp_rd.push_back(16'h0500); spi_xfer(8'h68, 16'h0, 16);

        // Temperature snapshot survives a mid-transfer change
        exp_rd.push_back(16'h0C80);
        fork
            spi_xfer(8'h50, 16'h0, 16);
            begin
                repeat ((1 + 2*12) * H) @(negedge clk);
                temp_in = 16'h1234;
            end
        join

        exp_wr.push_back(3'd6); spi_xfer(8'h30, 16'h2A00, 16);
        check("wr_addr_after_w6", {29'h0, wr_addr}, 32'h6);
        exp_rd.push_back(16'h2A00); spi_xfer(8'h70, 16'h0, 16);

        exp_wr.push_back(3'd1); spi_xfer(8'h08, 16'h4000, 8);
        check("cfg_after_w1", {24'h0, cfg}, 32'h40);
        exp_rd.push_back(16'h4000); spi_xfer(8'h48, 16'h0, 16);

        // Read-only write: no strobe, temperature still live
        spi_xfer(8'h10, 16'hFFFF, 16);
        exp_rd.push_back(16'h1234); spi_xfer(8'h50, 16'h0, 16);

        // Deselect after 5 data bits of a T_CRIT write
        spi_xfer(8'h20, 16'h1111, 5);
        check("dout_after_abort", {31'h0, dout}, 32'h1);
        exp_rd.push_back(16'h4980); spi_xfer(8'h60, 16'h0, 16);

        // Reset during a T_LOW read; cs stays low afterwards
        fork
            spi_xfer(8'h78, 16'h0, 16);
            begin
                repeat ((1 + 2*14) * H) @(negedge clk);
                reset = 1'b1;
                #1;
                check("dout_in_reset", {31'h0, dout}, 32'h1);
                check("state_in_reset", 32'(dut.state), 32'(ST_IDLE));
                repeat (3) @(negedge clk);
                reset = 1'b0;
                repeat (6 * H) @(negedge clk);
                check("state_after_reset_cs_low", 32'(dut.state), 32'(ST_IDLE));
                check("dout_after_reset_cs_low", {31'h0, dout}, 32'h1);
            end
        join
        check("cfg_after_reset", {24'h0, cfg}, 32'h0);
        exp_rd.push_back(16'h0500); spi_xfer(8'h78, 16'h0, 16);

        repeat (20) @(negedge clk);
        check("pending_reads", exp_rd.size(), 32'h0);
        check("pending_writes", exp_wr.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
